// File: rtl/capture_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : capture_pkg
//  Brief    : Shared types and constants for the ADC capture sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package capture_pkg;

    localparam int TDATA_W            = 32;
    localparam int DEFAULT_SAMPLE_W   = 16;
    localparam int DEFAULT_FIFO_DEPTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/capture_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : capture_fifo
//  Brief    : Synchronous FIFO with a registered output stage and flush.
//  Revision : 1.0 - initial release
// ============================================================================
module capture_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    output logic             empty,
    input  logic             rd_ready,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_cnt;
    logic             r_ov;
    logic [WIDTH-1:0] r_od;

    logic w_load;
    logic w_mem_rd;
    logic w_bypass;
    logic w_mem_wr;

    // The output register refills whenever it is empty or being consumed;
    // an empty array lets a write go straight into it.
    assign w_load   = !r_ov || rd_ready;
    assign w_mem_rd = w_load && (r_cnt != '0);
    assign w_bypass = w_load && (r_cnt == '0) && wr_en;
    assign w_mem_wr = wr_en && !w_bypass && !full;

    assign full     = (r_cnt == (AW+1)'(DEPTH));
    assign empty    = (r_cnt == '0) && !r_ov;
    assign rd_valid = r_ov;
    assign rd_data  = r_od;

    always_ff @(posedge clk) begin
        if (w_mem_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_ov     <= 1'b0;
            r_od     <= '0;
        end else begin
            if (w_mem_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_mem_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_mem_wr, w_mem_rd})
                2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
            if (w_load) begin
                if (w_mem_rd) begin
                    r_ov <= 1'b1;
                    r_od <= r_mem[r_rd_ptr];
                end else if (w_bypass) begin
                    r_ov <= 1'b1;
                    r_od <= wr_data;
                end else begin
                    r_ov <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/adc_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : adc_capture_ctrl
//  Brief    : Packs ADC sample pairs into an N-beat AXI-Stream packet for DMA.
//             Optional rising-edge trigger when CAPTURE_TRIGGER_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module adc_capture_ctrl
    import capture_pkg::*;
#(
    parameter int SAMPLE_W   = DEFAULT_SAMPLE_W,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int SIZE_W     = 32
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic                abort,
    input  logic [SIZE_W-1:0]   packet_size,
`ifdef CAPTURE_TRIGGER_EN
    input  logic [SAMPLE_W-1:0] trig_level,
`endif
    input  logic                adc_valid,
    input  logic [SAMPLE_W-1:0] adc_data,
    output logic [TDATA_W-1:0]  m_axis_tdata,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic                m_axis_tlast,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    output logic [SIZE_W-3:0]   words_sent
);

    localparam logic [SIZE_W-3:0] c_CNT_ONE = 1;

    state_t              r_state;
    state_t              w_next;
    logic [SIZE_W-3:0]   r_n;
    logic [SIZE_W-3:0]   r_pushed;
    logic [SIZE_W-3:0]   r_words;
    logic                r_phase;
    logic [SAMPLE_W-1:0] r_lo;
    logic                r_push;
    logic [TDATA_W-1:0]  r_push_data;
    logic                r_overflow;

    logic [SIZE_W-3:0]   w_n;
    logic                w_start_ok;
    logic                w_trig_hit;
    logic                w_take;
    logic                w_push_ok;
    logic                w_drop;
    logic                w_last_word;
    logic                w_hs;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic                w_unused_bits;

    assign w_n         = packet_size[SIZE_W-1:2];
    assign w_start_ok  = start && !abort && (r_state == ST_IDLE) && (w_n != '0);
    assign w_take      = adc_valid && ((r_state == ST_CAPTURE) || w_trig_hit);
    assign w_push_ok   = r_push && (r_state == ST_CAPTURE) && !w_fifo_full;
    assign w_drop      = r_push && (r_state == ST_CAPTURE) && w_fifo_full;
    assign w_last_word = (r_pushed == r_n - c_CNT_ONE);
    assign w_hs        = m_axis_tvalid && m_axis_tready;

    assign overflow      = r_overflow;
    assign words_sent    = r_words;
    assign w_unused_bits = &{1'b0, packet_size[1:0], w_fifo_empty};

`ifdef CAPTURE_TRIGGER_EN
    logic [SAMPLE_W-1:0] r_prev;

    assign w_trig_hit = (r_state == ST_ARMED) && adc_valid &&
                        ($signed(r_prev) < $signed(trig_level)) &&
                        ($signed(adc_data) >= $signed(trig_level));

    // Starting from the most negative value lets a first sample already at
    // or above the threshold count as a crossing.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_prev <= '0;
        end else if (w_start_ok) begin
            r_prev <= {1'b1, {(SAMPLE_W-1){1'b0}}};
        end else if ((r_state == ST_ARMED) && adc_valid) begin
            r_prev <= adc_data;
        end
    end
`else
    assign w_trig_hit = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
`ifdef CAPTURE_TRIGGER_EN
                    w_next = ST_ARMED;
`else
                    w_next = ST_CAPTURE;
`endif
                end
            end
            ST_ARMED: begin
                busy = 1'b1;
                if (w_trig_hit) w_next = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                busy = 1'b1;
                if (w_push_ok && w_last_word) w_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (w_hs && m_axis_tlast) w_next = ST_DONE;
            end
            ST_DONE: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
        if (abort) w_next = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_n         <= '0;
            r_pushed    <= '0;
            r_words     <= '0;
            r_phase     <= 1'b0;
            r_lo        <= '0;
            r_push      <= 1'b0;
            r_push_data <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_start_ok) begin
                r_words <= '0;
            end else if (w_hs) begin
                r_words <= r_words + c_CNT_ONE;
            end
            if (abort) begin
                r_phase <= 1'b0;
                r_push  <= 1'b0;
            end else if (w_start_ok) begin
                r_n        <= w_n;
                r_pushed   <= '0;
                r_overflow <= 1'b0;
                r_phase    <= 1'b0;
                r_push     <= 1'b0;
            end else begin
                r_push <= 1'b0;
                if (w_take) begin
                    if (!r_phase) begin
                        r_lo    <= adc_data;
                        r_phase <= 1'b1;
                    end else begin
                        r_push      <= 1'b1;
                        r_push_data <= {adc_data, r_lo};
                        r_phase     <= 1'b0;
                    end
                end
                // A dropped word leaves the count alone so the packet is
                // always exactly N beats long.
                if (w_push_ok) r_pushed <= r_pushed + c_CNT_ONE;
                if (w_drop)    r_overflow <= 1'b1;
            end
        end
    end

    capture_fifo #(
        .WIDTH (TDATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .flush    (abort),
        .wr_en    (w_push_ok),
        .wr_data  ({w_last_word, r_push_data}),
        .full     (w_fifo_full),
        .empty    (w_fifo_empty),
        .rd_ready (m_axis_tready),
        .rd_valid (m_axis_tvalid),
        .rd_data  ({m_axis_tlast, m_axis_tdata})
    );

endmodule
`default_nettype wire

// File: tb/tb_adc_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adc_capture_ctrl
//  Brief    : Self-checking bench for adc_capture_ctrl with a pair-packing model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_adc_capture_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] packet_size = '0;
    logic [15:0] trig_level = '0;
    logic        adc_valid = 1'b0;
    logic [15:0] adc_data = '0;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tlast;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [29:0] words_sent;

    int          checks = 0;
    int          errors = 0;
    int          ready_mode = 0;
    int          rdy_phase = 0;

    logic [31:0] got_data[$];
    logic        got_last[$];
    int          done_cnt = 0;
    int          done_busy_bad = 0;
    int          stall_viol = 0;
    logic        prev_stall = 1'b0;
    logic [32:0] prev_beat = '0;

    always #5 clk = ~clk;

    adc_capture_ctrl dut (
        .clk           (clk),
        .resetn        (resetn),
        .start         (start),
        .abort         (abort),
        .packet_size   (packet_size),
`ifdef CAPTURE_TRIGGER_EN
        .trig_level    (trig_level),
`endif
        .adc_valid     (adc_valid),
        .adc_data      (adc_data),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .busy          (busy),
        .done          (done),
        .overflow      (overflow),
        .words_sent    (words_sent)
    );

    // Sink ready pattern: 0 = always, 1 = random without two lows in a row, 2 = one in three.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: m_axis_tready = 1'b1;
            1: m_axis_tready = !m_axis_tready ? 1'b1 : ($urandom_range(0, 1) == 1);
            2: begin
                rdy_phase = (rdy_phase + 1) % 3;
                m_axis_tready = (rdy_phase == 0);
            end
            default: m_axis_tready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (m_axis_tvalid && m_axis_tready) begin
            got_data.push_back(m_axis_tdata);
            got_last.push_back(m_axis_tlast);
        end
        if (done) done_cnt++;
        if (done && busy) done_busy_bad++;
        if (prev_stall && (!m_axis_tvalid || {m_axis_tlast, m_axis_tdata} != prev_beat))
            stall_viol++;
        prev_stall = m_axis_tvalid && !m_axis_tready && !abort && resetn;
        prev_beat  = {m_axis_tlast, m_axis_tdata};
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [31:0] size);
        tick();
        adc_valid = 1'b0;
        packet_size = size;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [15:0] v);
        tick();
        adc_valid = 1'b1;
        adc_data = v;
    endtask

    task automatic idle();
        tick();
        adc_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Expected packet: consecutive sample pairs, first sample in the low half.
    function automatic void build_exp(input logic [15:0] s[$], input int n, ref logic [31:0] e[$]);
        e.delete();
        for (int k = 0; k < n; k++) e.push_back({s[2*k+1], s[2*k]});
    endfunction

    // Number of disagreements between received beats (from base) and the expected list.
    function automatic int beat_errs(input int base, input logic [31:0] e[$]);
        int bad;
        int n;
        n = got_data.size() - base;
        bad = (n == e.size()) ? 0 : 1;
        for (int k = 0; k < n && k < e.size(); k++) begin
            if (got_data[base+k] !== e[k]) bad++;
            if (got_last[base+k] !== (k == e.size() - 1)) bad++;
        end
        return bad;
    endfunction

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({m_axis_tvalid, m_axis_tlast, busy, done, overflow} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b exp 00000", {m_axis_tvalid, m_axis_tlast, busy, done, overflow});
        end
        checks++;
        if (m_axis_tdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_tdata got %h exp 0", m_axis_tdata);
        end
        checks++;
        if (words_sent !== 30'd0) begin
            errors++;
            $display("FAIL reset_words got %0d exp 0", words_sent);
        end
        tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [15:0] s[$];
        logic [31:0] e[$];
        int base, dbase, bad;
        bit ok;
        ready_mode = 0;
        base = got_data.size();
        dbase = done_cnt;
        pulse_start(32'd2048);
        for (int i = 0; i < 1024; i++) begin
            s.push_back(16'(i));
            send(16'(i));
        end
        idle();
        wait_done(200, ok);
        repeat (3) @(negedge clk);
        build_exp(s, 512, e);
        bad = beat_errs(base, e);
        checks++;
        if (!ok || bad !== 0) begin
            errors++;
            $display("FAIL basic_beats got %0d beats, %0d bad, done_seen %0d exp 512 beats 0 bad", got_data.size() - base, bad, ok);
        end
        checks++;
        if (done_cnt - dbase !== 1) begin
            errors++;
            $display("FAIL basic_done got %0d pulses exp 1", done_cnt - dbase);
        end
        checks++;
        if (words_sent !== 30'd512 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL basic_status got words %0d ovf %b exp 512 0", words_sent, overflow);
        end
    endtask

    task automatic test_size_edge();
        logic [15:0] s[$];
        logic [31:0] e[$];
        logic        seen_busy;
        logic [15:0] s0, s1;
        int base, dbase, bad;
        bit ok;
        ready_mode = 0;
        // N = 0 (size 0 and size 3) must never start
        seen_busy = 1'b0;
        pulse_start(32'd0);
        pulse_start(32'd3);
        repeat (3) begin
            @(negedge clk);
            seen_busy |= busy;
        end
        checks++;
        if (seen_busy !== 1'b0) begin
            errors++;
            $display("FAIL size0_busy got %b exp 0", seen_busy);
        end
        // size 6 -> one beat, also measures sample-to-tvalid latency
        base = got_data.size();
        dbase = done_cnt;
        s0 = 16'($urandom);
        s1 = 16'($urandom);
        pulse_start(32'd6);
        send(s0);
        send(s1);
        idle();
        @(negedge clk);
        checks++;
        if (m_axis_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early got tvalid %b exp 0", m_axis_tvalid);
        end
        @(negedge clk);
        checks++;
        if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== {2'b11, s1, s0}) begin
            errors++;
            $display("FAIL size6_beat got v%b l%b %h exp v1 l1 %h", m_axis_tvalid, m_axis_tlast, m_axis_tdata, {s1, s0});
        end
        wait_done(20, ok);
        repeat (2) @(negedge clk);
        checks++;
        if (!ok || got_data.size() - base !== 1 || words_sent !== 30'd1 || done_cnt - dbase !== 1) begin
            errors++;
            $display("FAIL size6_count got beats %0d words %0d done %0d exp 1 1 1", got_data.size() - base, words_sent, done_cnt - dbase);
        end
        // start while busy is ignored
        base = got_data.size();
        pulse_start(32'd16);
        for (int i = 0; i < 2; i++) begin
            s.push_back(16'($urandom));
            send(s[$]);
        end
        pulse_start(32'd8);
        for (int i = 0; i < 6; i++) begin
            s.push_back(16'($urandom));
            send(s[$]);
        end
        idle();
        wait_done(50, ok);
        repeat (2) @(negedge clk);
        build_exp(s, 4, e);
        bad = beat_errs(base, e);
        checks++;
        if (!ok || bad !== 0 || words_sent !== 30'd4) begin
            errors++;
            $display("FAIL start_busy got beats %0d bad %0d words %0d exp 4 0 4", got_data.size() - base, bad, words_sent);
        end
    endtask

    task automatic test_random();
        logic [15:0] s[$];
        logic [31:0] e[$];
        int base, dbase, bad, n, sbase;
        bit ok;
        ready_mode = 1;
        for (int it = 0; it < 6; it++) begin
            s.delete();
            n = $urandom_range(1, 40);
            base = got_data.size();
            dbase = done_cnt;
            sbase = stall_viol;
            pulse_start(32'(n * 4 + $urandom_range(0, 3)));
            for (int i = 0; i < 2 * n; i++) begin
                if ($urandom_range(0, 9) < 3) idle();
                s.push_back(16'($urandom));
                send(s[$]);
            end
            idle();
            wait_done(400, ok);
            repeat (2) @(negedge clk);
            build_exp(s, n, e);
            bad = beat_errs(base, e);
            checks++;
            if (!ok || bad !== 0 || stall_viol - sbase !== 0) begin
                errors++;
                $display("FAIL random_beats it %0d got %0d beats bad %0d stall %0d exp %0d beats", it, got_data.size() - base, bad, stall_viol - sbase, n);
            end
            checks++;
            if (words_sent !== 30'(n) || overflow !== 1'b0 || done_cnt - dbase !== 1) begin
                errors++;
                $display("FAIL random_status it %0d got words %0d ovf %b done %0d exp %0d 0 1", it, words_sent, overflow, done_cnt - dbase, n);
            end
        end
    endtask

    task automatic test_back_pressure();
        int base, sbase, bad, prev_m, m;
        bit ok, stop;
        ready_mode = 2;
        base = got_data.size();
        sbase = stall_viol;
        stop = 1'b0;
        pulse_start(32'd2048);
        fork
            begin
                int v;
                v = 0;
                while (!stop && v < 20000) begin
                    send(16'(v));
                    v++;
                end
                idle();
            end
            begin
                wait_done(10000, ok);
                stop = 1'b1;
            end
        join
        repeat (2) @(negedge clk);
        // Drops remove whole pairs, so each beat is some {2m+1, 2m} with m rising from 0.
        bad = 0;
        prev_m = -1;
        for (int k = 0; k < got_data.size() - base; k++) begin
            m = int'(got_data[base+k][15:0]) / 2;
            if (got_data[base+k][15:0] !== 16'(2 * m) || got_data[base+k][31:16] !== 16'(2 * m + 1)) bad++;
            if ((k == 0 && m != 0) || m <= prev_m) bad++;
            if (got_last[base+k] !== (k == 511)) bad++;
            prev_m = m;
        end
        checks++;
        if (!ok || got_data.size() - base !== 512 || bad !== 0) begin
            errors++;
            $display("FAIL bp_beats got %0d beats bad %0d done_seen %0d exp 512 0 1", got_data.size() - base, bad, ok);
        end
        checks++;
        if (overflow !== 1'b1 || words_sent !== 30'd512) begin
            errors++;
            $display("FAIL bp_status got ovf %b words %0d exp 1 512", overflow, words_sent);
        end
        checks++;
        if (stall_viol - sbase !== 0) begin
            errors++;
            $display("FAIL bp_stable got %0d unstable stalls exp 0", stall_viol - sbase);
        end
    endtask

    task automatic test_abort();
        logic [15:0] s[$];
        logic [31:0] e[$];
        int base, dbase, bad;
        bit ok, stop, reached;
        ready_mode = 0;
        base = got_data.size();
        dbase = done_cnt;
        stop = 1'b0;
        reached = 1'b0;
        pulse_start(32'd2048);
        fork
            begin
                int v;
                v = 0;
                while (!stop && v < 5000) begin
                    send(16'(v));
                    v++;
                end
                idle();
            end
            begin
                for (int c = 0; c < 1000 && !reached; c++) begin
                    @(negedge clk);
                    if (got_data.size() - base >= 100) reached = 1'b1;
                end
                tick();
                abort = 1'b1;
                stop = 1'b1;
                tick();
                abort = 1'b0;
            end
        join_any
        @(negedge clk);
        checks++;
        if (!reached || m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_stop got tvalid %b busy %b reached %0d exp 0 0 1", m_axis_tvalid, busy, reached);
        end
        wait fork;
        repeat (10) @(negedge clk);
        checks++;
        if (done_cnt - dbase !== 0) begin
            errors++;
            $display("FAIL abort_nodone got %0d pulses exp 0", done_cnt - dbase);
        end
        base = got_data.size();
        dbase = done_cnt;
        pulse_start(32'd8);
        for (int i = 0; i < 4; i++) begin
            s.push_back(16'($urandom));
            send(s[$]);
        end
        idle();
        wait_done(50, ok);
        repeat (2) @(negedge clk);
        build_exp(s, 2, e);
        bad = beat_errs(base, e);
        checks++;
        if (!ok || bad !== 0 || done_cnt - dbase !== 1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL abort_next got beats %0d bad %0d done %0d ovf %b exp 2 0 1 0", got_data.size() - base, bad, done_cnt - dbase, overflow);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] s[$];
        logic [31:0] e[$];
        int base, dbase, bad;
        bit ok;
        ready_mode = 1;
        pulse_start(32'd2048);
        for (int i = 0; i < 300; i++) send(16'(i));
        tick();
        resetn = 1'b0;
        adc_valid = 1'b0;
        tick();
        resetn = 1'b1;
        @(negedge clk);
        checks++;
        if ({m_axis_tvalid, m_axis_tlast, busy, done, overflow, m_axis_tdata, words_sent} !== 67'd0) begin
            errors++;
            $display("FAIL midreset_out got v%b l%b b%b d%b o%b %h %0d exp all 0", m_axis_tvalid, m_axis_tlast, busy, done, overflow, m_axis_tdata, words_sent);
        end
        base = got_data.size();
        dbase = done_cnt;
        pulse_start(32'd256);
        for (int i = 0; i < 128; i++) begin
            s.push_back(16'($urandom));
            send(s[$]);
        end
        idle();
        wait_done(300, ok);
        repeat (2) @(negedge clk);
        build_exp(s, 64, e);
        bad = beat_errs(base, e);
        checks++;
        if (!ok || bad !== 0 || words_sent !== 30'd64 || done_cnt - dbase !== 1) begin
            errors++;
            $display("FAIL midreset_next got beats %0d bad %0d words %0d done %0d exp 64 0 64 1", got_data.size() - base, bad, words_sent, done_cnt - dbase);
        end
    endtask

`ifdef CAPTURE_TRIGGER_EN
    task automatic test_trigger();
        logic [31:0] e[$];
        int base, dbase, bad;
        ready_mode = 0;
        trig_level = 16'd500;
        base = got_data.size();
        dbase = done_cnt;
        pulse_start(32'd8);
        for (int i = 0; i < 600; i++) send(16'(i));
        idle();
        repeat (5) @(negedge clk);
        e.push_back({16'd501, 16'd500});
        e.push_back({16'd503, 16'd502});
        bad = beat_errs(base, e);
        checks++;
        if (bad !== 0 || done_cnt - dbase !== 1) begin
            errors++;
            $display("FAIL trigger_beats got %0d beats bad %0d done %0d exp 2 0 1", got_data.size() - base, bad, done_cnt - dbase);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_size_edge();
        test_random();
        test_back_pressure();
        test_abort();
        test_reset_mid();
`ifdef CAPTURE_TRIGGER_EN
        test_trigger();
`endif
        checks++;
        if (done_busy_bad !== 0) begin
            errors++;
            $display("FAIL done_busy got %0d cycles with done and busy exp 0", done_busy_bad);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adc_capture_ctrl.md
# adc_capture_ctrl

Capture sequencer between the ADC receive path and the AXI DMA S2MM stream input. On a software start it collects a programmed number of bytes of 16-bit ADC samples and packs sample pairs into 32-bit AXI-Stream beats. It buffers against DMA back-pressure, terminates the packet with `tlast`, and reports busy, done and overflow status to the register block at 0x6000_0000.

## Interface
Parameters:
- `SAMPLE_W`, 16: ADC sample width.
- `FIFO_DEPTH`, 16: output FIFO depth in 32-bit words; must be a power of two.
- `SIZE_W`, 32: width of the packet size register.

Ports:
- `clk`, in, 1: single clock for the whole block.
- `resetn`, in, 1: reset. Synchronous, active-low.
- `start`, in, 1: one-cycle start pulse from the register block.
- `abort`, in, 1: one-cycle recovery pulse.
- `packet_size`, in, `SIZE_W`: packet length in bytes. Sampled only when a start is accepted.
- `trig_level`, in, `SAMPLE_W`: signed trigger threshold. Present only with `CAPTURE_TRIGGER_EN`.
- `adc_valid`, in, 1: a sample is present this cycle. The upstream path has already moved it into the `clk` domain.
- `adc_data`, in, `SAMPLE_W`: sample value, two's complement.
- `m_axis_tdata`, out, 32: packed sample pair.
- `m_axis_tvalid`, out, 1: AXI-Stream valid.
- `m_axis_tready`, in, 1: AXI-Stream ready.
- `m_axis_tlast`, out, 1: asserted on the final beat of the packet.
- `busy`, out, 1: high in ARMED, CAPTURE and DRAIN.
- `done`, out, 1: one-cycle pulse at packet completion.
- `overflow`, out, 1: sticky; a word was dropped because the FIFO was full.
- `words_sent`, out, `SIZE_W-2`: number of beats accepted in the current or most recent packet.

## Operation
- Word count: N = `packet_size[SIZE_W-1:2]`. The low two bits are ignored. If N is 0, `start` is ignored.
- States and transitions:
  - IDLE to CAPTURE on `start` with N ≠ 0. With `CAPTURE_TRIGGER_EN`, the target is ARMED instead.
  - ARMED to CAPTURE on the trigger sample (see Configuration).
  - CAPTURE to DRAIN once N words have been pushed.
  - DRAIN to DONE on the handshake of the `tlast` beat.
  - DONE to IDLE unconditionally after one cycle.
- On an accepted start: latch N, clear `words_sent` and `overflow`, and reset the packer phase to the low half.
- Packing: the first sample of a pair goes to `tdata[15:0]` and the second to `tdata[31:16]`. Gaps in `adc_valid` are allowed.
- Push: a word is pushed in the cycle after its second sample is accepted.
- FIFO full at push: the word is dropped, `overflow` is set, and the pushed-word count does not advance. The packet therefore always carries exactly N beats.
- `tlast` is asserted on the beat whose index equals N-1.
- `words_sent` increments on each `tvalid && tready` handshake.
- Samples arriving in IDLE, DONE or DRAIN are discarded.
- `start` while `busy` is ignored.
- `abort` from any state:
  - Next state is IDLE and the FIFO is flushed.
  - `tvalid` drops the next cycle. This is an AXI-Stream violation; software must reset the DMA alongside an abort.
  - No `done` pulse is produced.
- If `abort` and `start` are asserted in the same cycle, `abort` wins.

## Timing
- All outputs reset to 0, including `words_sent`, `overflow` and the FIFO pointers. The state resets to IDLE.
- Reset asserted mid-packet has the same effect as a full reset; no `done` pulse is produced.
- Accepted `start` to `busy` = 1: one cycle.
- Second sample of a pair to `m_axis_tvalid`: two cycles. One cycle for the push, one for the registered FIFO output.
- While `tvalid` is high and `tready` is low, `tdata` and `tlast` hold stable.
- With `tready` held high, the block sustains one beat per cycle.
- `done`: high in the DONE cycle only, which is the cycle after the last handshake. `busy` is 0 in that same cycle.

## Configuration
- `CAPTURE_TRIGGER_EN`, defined:
  - Adds the `trig_level` port and the ARMED state.
  - The trigger is a rising crossing: previous valid sample < `trig_level` and current sample ≥ `trig_level`, compared signed.
  - The triggering sample is the first captured sample.
  - The previous-sample register is cleared to the most negative value on entering ARMED.
- `CAPTURE_TRIGGER_EN`, undefined: no port, no ARMED state; capture starts on `start`.

## Structure
- Package `capture_pkg`:
  - State enum (IDLE, ARMED, CAPTURE, DRAIN, DONE).
  - `TDATA_W` = 32.
  - Default `SAMPLE_W` and `FIFO_DEPTH`.
- Sub-module `capture_fifo`:
  - Synchronous FIFO of 33 bits (data plus last).
  - Registered output, full/empty flags, flush input.

## Test plan
- Basic packet:
  - Stimulus: `packet_size` = 2048, samples 0..1023 on consecutive cycles, `tready` = 1.
  - Response: 512 beats; beat k carries {2k+1, 2k}; `tlast` only on beat 511; one `done` pulse; `words_sent` = 512.
- Back-pressure:
  - Stimulus: same packet with `tready` high one cycle in three and continuous samples.
  - Response: `overflow` = 1; exactly 512 beats; `tlast` on beat 511 only; `tdata` stable while stalled.
- Size edge cases:
  - `packet_size` = 0 with `start`: `busy` stays 0.
  - `packet_size` = 6: exactly 1 beat, with `tlast` = 1.
  - `start` while busy: ignored.
- Abort:
  - Stimulus: `abort` after 100 beats.
  - Response: `tvalid` = 0 and `busy` = 0 next cycle, no `done` pulse. A following `start` with size 8 yields 2 clean beats.
- Trigger (`CAPTURE_TRIGGER_EN`):
  - Stimulus: `trig_level` = 500, ramp from 0, `packet_size` = 8.
  - Response: beats {501, 500} and {503, 502}.
- Reset mid-packet:
  - Stimulus: `resetn` = 0 for one cycle during CAPTURE.
  - Response: all outputs 0. The next start produces a full, correctly packed packet.
